// File: rtl/clause_pkg.sv
// Shared encodings for the clause scan engine: per-slot dynamic status,
// per-row classification and result-kind codes.
package clause_pkg;

    localparam logic [1:0] DYN_UNASSIGNED = 2'b00;
    localparam logic [1:0] DYN_FALSE      = 2'b01;
    localparam logic [1:0] DYN_TRUE       = 2'b10;
    localparam logic [1:0] DYN_RESERVED   = 2'b11;

    typedef enum logic [2:0] {
        IGNORE,
        SATISFIED,
        CONFLICT,
        UNIT,
        UNRESOLVED
    } clause_status_e;

    localparam logic RES_KIND_UNIT     = 1'b0;
    localparam logic RES_KIND_CONFLICT = 1'b1;

    function automatic logic status_needs_push(input clause_status_e s);
        return (s == UNIT) || (s == CONFLICT);
    endfunction

endpackage

// File: rtl/clause_status_eval.sv
// Combinational classifier for one clause row: derives the row status and,
// for UNIT rows, the code of the single open literal.
module clause_status_eval
    import clause_pkg::*;
#(
    parameter int COLS_PER_ROW = 4,
    parameter int LIT_WIDTH    = 6
) (
    input  logic [COLS_PER_ROW*LIT_WIDTH-1:0] static_row,
    input  logic [2*COLS_PER_ROW-1:0]         dyn_row,
    output clause_status_e                    status,
    output logic [LIT_WIDTH-1:0]              unit_lit
);

    logic                 any_active;
    logic                 any_true;
    logic [1:0]           open_cnt;
    logic [LIT_WIDTH-1:0] open_lit;
    logic [LIT_WIDTH-1:0] slot_lit;
    logic [1:0]           slot_st;

    // open_cnt saturates at 2: only "none", "one" and "more" matter.
    always_comb begin
        any_active = 1'b0;
        any_true   = 1'b0;
        open_cnt   = 2'd0;
        open_lit   = '0;
        slot_lit   = '0;
        slot_st    = DYN_UNASSIGNED;
        for (int unsigned i = 0; i < COLS_PER_ROW; i++) begin
            slot_lit = static_row[i*LIT_WIDTH +: LIT_WIDTH];
            slot_st  = dyn_row[2*i +: 2];
            if (slot_lit != '0) begin
                any_active = 1'b1;
                if (slot_st == DYN_TRUE) begin
                    any_true = 1'b1;
                end else if ((slot_st == DYN_UNASSIGNED) || (slot_st == DYN_RESERVED)) begin
                    if (open_cnt != 2'd2) begin
                        open_cnt = open_cnt + 2'd1;
                    end
                    open_lit = slot_lit;
                end
            end
        end
    end

    always_comb begin
        status = UNRESOLVED;
        if (!any_active) begin
            status = IGNORE;
        end else if (any_true) begin
            status = SATISFIED;
        end else if (open_cnt == 2'd0) begin
            status = CONFLICT;
        end else if (open_cnt == 2'd1) begin
            status = UNIT;
        end
    end

    assign unit_lit = (status == UNIT) ? open_lit : '0;

endmodule

// File: rtl/clause_scan_engine.sv
// Scans NUM_ROWS clause rows per pass, classifies each fetched row and streams
// UNIT / CONFLICT results through a 2-entry FIFO in row order.
module clause_scan_engine
    import clause_pkg::*;
#(
    parameter int COLS_PER_ROW     = 4,
    parameter int LIT_WIDTH        = 6,
    parameter int NUM_ROWS         = 64,
    parameter int STOP_ON_CONFLICT = 1,
    localparam int ROW_AW          = $clog2(NUM_ROWS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              row_req,
    output logic [ROW_AW-1:0]                 row_addr,
    input  logic                              row_valid,
    input  logic [COLS_PER_ROW*LIT_WIDTH-1:0] static_row,
    input  logic [2*COLS_PER_ROW-1:0]         dyn_row,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [ROW_AW-1:0]                 res_row,
    output logic                              res_kind,
    output logic [LIT_WIDTH-1:0]              res_lit,
    output logic                              conflict_found,
    output logic [ROW_AW:0]                   unit_count
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        EVAL,
        DRAIN
    } state_e;

    state_e                            state;
    logic [COLS_PER_ROW*LIT_WIDTH-1:0] static_q;
    logic [2*COLS_PER_ROW-1:0]         dyn_q;
    clause_status_e                    row_status;
    logic [LIT_WIDTH-1:0]              row_lit;

    logic [ROW_AW-1:0]    fifo_row  [2];
    logic                 fifo_kind [2];
    logic [LIT_WIDTH-1:0] fifo_lit  [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           fifo_count;

    logic need_push;
    logic push;
    logic pop;
    logic eval_stall;
    logic last_row;
    logic stop_here;

    clause_status_eval #(
        .COLS_PER_ROW (COLS_PER_ROW),
        .LIT_WIDTH    (LIT_WIDTH)
    ) u_eval (
        .static_row (static_q),
        .dyn_row    (dyn_q),
        .status     (row_status),
        .unit_lit   (row_lit)
    );

    assign res_valid = (fifo_count != 2'd0);
    assign res_row   = fifo_row[rd_ptr];
    assign res_kind  = fifo_kind[rd_ptr];
    assign res_lit   = fifo_lit[rd_ptr];

    // A pop in the same cycle frees the slot the push lands in, so a full
    // FIFO only stalls EVAL when the consumer is not draining.
    assign pop        = res_valid && res_ready;
    assign need_push  = (state == EVAL) && status_needs_push(row_status);
    assign push       = need_push && ((fifo_count != 2'd2) || pop);
    assign eval_stall = need_push && !push;
    assign last_row   = (row_addr == ROW_AW'(NUM_ROWS - 1));
    assign stop_here  = (STOP_ON_CONFLICT != 0) && (row_status == CONFLICT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_row[i]  <= '0;
                fifo_kind[i] <= RES_KIND_UNIT;
                fifo_lit[i]  <= '0;
            end
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) begin
                fifo_row[wr_ptr]  <= row_addr;
                fifo_kind[wr_ptr] <= (row_status == CONFLICT) ? RES_KIND_CONFLICT : RES_KIND_UNIT;
                fifo_lit[wr_ptr]  <= (row_status == CONFLICT) ? '0 : row_lit;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            row_req        <= 1'b0;
            row_addr       <= '0;
            static_q       <= '0;
            dyn_q          <= '0;
            conflict_found <= 1'b0;
            unit_count     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= REQ;
                        busy           <= 1'b1;
                        row_req        <= 1'b1;
                        row_addr       <= '0;
                        conflict_found <= 1'b0;
                        unit_count     <= '0;
                    end
                end
                REQ: begin
                    row_req <= 1'b0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (row_valid) begin
                        static_q <= static_row;
                        dyn_q    <= dyn_row;
                        state    <= EVAL;
                    end
                end
                EVAL: begin
                    if (!eval_stall) begin
                        if ((row_status == UNIT) && (unit_count != '1)) begin
                            unit_count <= unit_count + 1'b1;
                        end
                        if (row_status == CONFLICT) begin
                            conflict_found <= 1'b1;
                        end
                        if (last_row || stop_here) begin
                            state <= DRAIN;
                        end else begin
                            state    <= REQ;
                            row_req  <= 1'b1;
                            row_addr <= row_addr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_count == 2'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clause_scan_engine.sv
// Randomized bench for clause_scan_engine: a memory responder with variable
// latency feeds three differently parameterised instances; results are checked
// against a row-by-row reference model.
module tb_clause_scan_engine;

    typedef struct {
        int row;
        int kind;
        int lit;
    } res_t;

    localparam int C_IGN   = 0;
    localparam int C_SAT   = 1;
    localparam int C_CONF  = 2;
    localparam int C_UNIT  = 3;
    localparam int C_UNRES = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        row_valid = 1'b0;
    logic        res_ready = 1'b0;
    logic [23:0] static_row = '0;
    logic [7:0]  dyn_row = '0;
    int          sel = 0;

    logic       a_start, a_row_valid, a_res_ready;
    logic       a_busy, a_done, a_row_req, a_res_valid, a_res_kind, a_conf;
    logic [1:0] a_row_addr, a_res_row;
    logic [5:0] a_res_lit;
    logic [2:0] a_units;

    logic       b_start, b_row_valid, b_res_ready;
    logic       b_busy, b_done, b_row_req, b_res_valid, b_res_kind, b_conf;
    logic [2:0] b_row_addr, b_res_row;
    logic [5:0] b_res_lit;
    logic [3:0] b_units;

    logic       c_start, c_row_valid, c_res_ready;
    logic       c_busy, c_done, c_row_req, c_res_valid, c_res_kind, c_conf;
    logic [2:0] c_row_addr, c_res_row;
    logic [5:0] c_res_lit;
    logic [3:0] c_units;

    int m_busy, m_done, m_row_req, m_row_addr, m_res_valid;
    int m_res_row, m_res_kind, m_res_lit, m_conf, m_units;

    int checks = 0;
    int failures = 0;

    // scenario-owned knobs
    int ready_mode = 0;
    int lat_min = 1;
    int lat_max = 1;
    int stray_en = 0;
    int clr_req = 0;
    int inject_req = 0;

    // responder-owned observations
    int   clr_seen = 0;
    int   inject_seen = 0;
    int   rsp_pending = 0;
    int   rsp_wait = 0;
    int   rsp_addr = 0;
    int   prev_req = 0;
    int   prev_valid = 0;
    int   prev_ready = 0;
    res_t prev_res;
    int   done_cnt = 0;
    int   busy_at_done = 0;
    int   err_outstanding = 0;
    int   err_req_len = 0;
    int   err_addr_hold = 0;
    int   err_stable = 0;
    int   req_q[$];
    res_t got_q[$];

    logic [23:0] row_static [8];
    logic [7:0]  row_dyn    [8];

    res_t exp_q[$];
    int   exp_last;
    int   exp_units;
    int   exp_conf;

    assign a_start     = start && (sel == 0);
    assign b_start     = start && (sel == 1);
    assign c_start     = start && (sel == 2);
    assign a_row_valid = row_valid && (sel == 0);
    assign b_row_valid = row_valid && (sel == 1);
    assign c_row_valid = row_valid && (sel == 2);
    assign a_res_ready = res_ready && (sel == 0);
    assign b_res_ready = res_ready && (sel == 1);
    assign c_res_ready = res_ready && (sel == 2);

    clause_scan_engine #(.COLS_PER_ROW(4), .LIT_WIDTH(6), .NUM_ROWS(4), .STOP_ON_CONFLICT(1)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .row_req(a_row_req), .row_addr(a_row_addr), .row_valid(a_row_valid),
        .static_row(static_row), .dyn_row(dyn_row), .res_valid(a_res_valid),
        .res_ready(a_res_ready), .res_row(a_res_row), .res_kind(a_res_kind),
        .res_lit(a_res_lit), .conflict_found(a_conf), .unit_count(a_units)
    );

    clause_scan_engine #(.COLS_PER_ROW(4), .LIT_WIDTH(6), .NUM_ROWS(8), .STOP_ON_CONFLICT(1)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .row_req(b_row_req), .row_addr(b_row_addr), .row_valid(b_row_valid),
        .static_row(static_row), .dyn_row(dyn_row), .res_valid(b_res_valid),
        .res_ready(b_res_ready), .res_row(b_res_row), .res_kind(b_res_kind),
        .res_lit(b_res_lit), .conflict_found(b_conf), .unit_count(b_units)
    );

    clause_scan_engine #(.COLS_PER_ROW(4), .LIT_WIDTH(6), .NUM_ROWS(8), .STOP_ON_CONFLICT(0)) u_c (
        .clk(clk), .rst(rst), .start(c_start), .busy(c_busy), .done(c_done),
        .row_req(c_row_req), .row_addr(c_row_addr), .row_valid(c_row_valid),
        .static_row(static_row), .dyn_row(dyn_row), .res_valid(c_res_valid),
        .res_ready(c_res_ready), .res_row(c_res_row), .res_kind(c_res_kind),
        .res_lit(c_res_lit), .conflict_found(c_conf), .unit_count(c_units)
    );

    always_comb begin
        m_busy = 0; m_done = 0; m_row_req = 0; m_row_addr = 0; m_res_valid = 0;
        m_res_row = 0; m_res_kind = 0; m_res_lit = 0; m_conf = 0; m_units = 0;
        case (sel)
            0: begin
                m_busy = int'(a_busy); m_done = int'(a_done); m_row_req = int'(a_row_req);
                m_row_addr = int'(a_row_addr); m_res_valid = int'(a_res_valid);
                m_res_row = int'(a_res_row); m_res_kind = int'(a_res_kind);
                m_res_lit = int'(a_res_lit); m_conf = int'(a_conf); m_units = int'(a_units);
            end
            1: begin
                m_busy = int'(b_busy); m_done = int'(b_done); m_row_req = int'(b_row_req);
                m_row_addr = int'(b_row_addr); m_res_valid = int'(b_res_valid);
                m_res_row = int'(b_res_row); m_res_kind = int'(b_res_kind);
                m_res_lit = int'(b_res_lit); m_conf = int'(b_conf); m_units = int'(b_units);
            end
            default: begin
                m_busy = int'(c_busy); m_done = int'(c_done); m_row_req = int'(c_row_req);
                m_row_addr = int'(c_row_addr); m_res_valid = int'(c_res_valid);
                m_res_row = int'(c_res_row); m_res_kind = int'(c_res_kind);
                m_res_lit = int'(c_res_lit); m_conf = int'(c_conf); m_units = int'(c_units);
            end
        endcase
    end

    always #5 clk = ~clk;

    // Row memory, result sink and protocol watcher, all working on falling edges.
    always @(negedge clk) begin
        row_valid = 1'b0;
        if (clr_req != clr_seen) begin
            clr_seen = clr_req;
            req_q.delete();
            got_q.delete();
            done_cnt = 0;
            busy_at_done = 0;
            err_outstanding = 0;
            err_req_len = 0;
            err_addr_hold = 0;
            err_stable = 0;
        end
        if (inject_req != inject_seen) begin
            inject_seen = inject_req;
            static_row = 24'($urandom);
            dyn_row = 8'($urandom);
            row_valid = 1'b1;
        end
        if (rst) begin
            rsp_pending = 0;
            prev_req = 0;
            prev_valid = 0;
            res_ready = 1'b0;
        end else begin
            if (rsp_pending != 0) begin
                if (m_row_addr != rsp_addr) err_addr_hold++;
                if (rsp_wait == 0) begin
                    static_row = row_static[rsp_addr];
                    dyn_row = row_dyn[rsp_addr];
                    row_valid = 1'b1;
                    rsp_pending = 0;
                end else begin
                    rsp_wait--;
                end
            end
            if (m_row_req != 0) begin
                if (rsp_pending != 0) err_outstanding++;
                if (prev_req != 0) err_req_len++;
                req_q.push_back(m_row_addr);
                rsp_addr = m_row_addr;
                rsp_pending = 1;
                rsp_wait = int'($urandom_range(lat_max, lat_min)) - 1;
                if (stray_en != 0) begin
                    static_row = 24'($urandom);
                    dyn_row = 8'($urandom);
                    row_valid = 1'b1;
                end
            end
            prev_req = m_row_req;

            if (prev_valid != 0 && prev_ready == 0) begin
                if (m_res_valid == 0 || m_res_row != prev_res.row ||
                    m_res_kind != prev_res.kind || m_res_lit != prev_res.lit) err_stable++;
            end
            case (ready_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = 1'($urandom_range(1, 0));
                default: res_ready = 1'b0;
            endcase
            if (m_res_valid != 0 && res_ready) got_q.push_back('{m_res_row, m_res_kind, m_res_lit});
            prev_valid = m_res_valid;
            prev_ready = int'(res_ready);
            prev_res = '{m_res_row, m_res_kind, m_res_lit};
            if (m_done != 0) begin
                done_cnt++;
                busy_at_done = m_busy;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic void classify(input logic [23:0] s, input logic [7:0] d,
                                     output int cls, output int lit);
        int n_act, n_true, n_open;
        int l, st;
        n_act = 0; n_true = 0; n_open = 0; lit = 0;
        for (int i = 0; i < 4; i++) begin
            l  = int'(s[i*6 +: 6]);
            st = int'(d[i*2 +: 2]);
            if (l != 0) begin
                n_act++;
                if (st == 2) n_true++;
                else if (st != 1) begin n_open++; lit = l; end
            end
        end
        if (n_act == 0) cls = C_IGN;
        else if (n_true > 0) cls = C_SAT;
        else if (n_open == 0) cls = C_CONF;
        else if (n_open == 1) cls = C_UNIT;
        else cls = C_UNRES;
    endfunction

    function automatic void build_model(input int nrows, input int stop);
        int cls, lit;
        exp_q.delete();
        exp_last = -1; exp_units = 0; exp_conf = 0;
        for (int r = 0; r < nrows; r++) begin
            exp_last = r;
            classify(row_static[r], row_dyn[r], cls, lit);
            if (cls == C_UNIT) begin exp_q.push_back('{r, 0, lit}); exp_units++; end
            if (cls == C_CONF) begin
                exp_q.push_back('{r, 1, 0});
                exp_conf = 1;
                if (stop != 0) break;
            end
        end
    endfunction

    task automatic random_rows();
        int v;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) begin
                row_static[r][i*6 +: 6] = ($urandom_range(3, 0) == 0) ? 6'd0 : 6'($urandom_range(63, 1));
                v = int'($urandom_range(9, 0));
                row_dyn[r][i*2 +: 2] = (v < 6) ? 2'b01 : (v < 8) ? 2'b00 : (v == 8) ? 2'b10 : 2'b11;
            end
        end
    endtask

    task automatic begin_pass(input int inst);
        sel = inst;
        clr_req++;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("busy_after_start", m_busy, 1);
        check_eq("units_cleared_on_start", m_units, 0);
        check_eq("conflict_cleared_on_start", m_conf, 0);
    endtask

    task automatic finish_pass(input int inst, input int spur);
        int n;
        int nrows;
        int stop;
        nrows = (inst == 0) ? 4 : 8;
        stop = (inst == 2) ? 0 : 1;
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            start = (spur != 0 && n == 4) ? 1'b1 : 1'b0;
            step();
            n++;
        end
        start = 1'b0;
        check_eq("pass_done_within_budget", (done_cnt != 0) ? 1 : 0, 1);
        repeat (3) step();
        build_model(nrows, stop);
        check_eq("done_once", done_cnt, 1);
        check_eq("busy_low_at_done", busy_at_done, 0);
        check_eq("busy_idle_after", m_busy, 0);
        check_eq("result_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check_eq("res_row", got_q[i].row, exp_q[i].row);
            check_eq("res_kind", got_q[i].kind, exp_q[i].kind);
            check_eq("res_lit", got_q[i].lit, exp_q[i].lit);
        end
        check_eq("rows_requested", req_q.size(), exp_last + 1);
        for (int i = 0; i < req_q.size(); i++) check_eq("req_addr_order", req_q[i], i);
        check_eq("unit_count", m_units, exp_units);
        check_eq("conflict_found", m_conf, exp_conf);
        check_eq("one_outstanding", err_outstanding, 0);
        check_eq("row_req_one_cycle", err_req_len, 0);
        check_eq("row_addr_hold", err_addr_hold, 0);
        check_eq("res_stable_when_stalled", err_stable, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_busy"}, m_busy, 0);
        check_eq({tag, "_done"}, m_done, 0);
        check_eq({tag, "_row_req"}, m_row_req, 0);
        check_eq({tag, "_row_addr"}, m_row_addr, 0);
        check_eq({tag, "_res_valid"}, m_res_valid, 0);
        check_eq({tag, "_res_row"}, m_res_row, 0);
        check_eq({tag, "_res_kind"}, m_res_kind, 0);
        check_eq({tag, "_res_lit"}, m_res_lit, 0);
        check_eq({tag, "_conflict"}, m_conf, 0);
        check_eq({tag, "_units"}, m_units, 0);
    endtask

    initial begin
        int n;
        random_rows();
        step();
        step();
        check_outputs_zero("reset");
        rst = 1'b0;
        step();

        // four rows: satisfied, unit on literal 5, unresolved, empty
        row_static[0] = {6'd0, 6'd0, 6'd0, 6'd3};  row_dyn[0] = 8'b00_00_00_10;
        row_static[1] = {6'd0, 6'd0, 6'd5, 6'd7};  row_dyn[1] = 8'b00_00_00_01;
        row_static[2] = {6'd0, 6'd0, 6'd9, 6'd8};  row_dyn[2] = 8'b00_00_00_00;
        row_static[3] = 24'd0;                     row_dyn[3] = 8'hFF;
        begin_pass(0);
        finish_pass(0, 0);
        check_eq("basic_one_result", got_q.size(), 1);
        check_eq("basic_unit_count", m_units, 1);

        // conflict on row 2 of 8 with early stop
        random_rows();
        row_static[0] = {6'd0, 6'd0, 6'd0, 6'd3};   row_dyn[0] = 8'b00_00_00_10;
        row_static[1] = {6'd0, 6'd0, 6'd4, 6'd2};   row_dyn[1] = 8'b00_00_00_00;
        row_static[2] = {6'd0, 6'd0, 6'd12, 6'd11}; row_dyn[2] = 8'b00_00_01_01;
        begin_pass(1);
        finish_pass(1, 0);
        check_eq("stop_last_addr", req_q.size(), 3);
        check_eq("stop_conflict", m_conf, 1);

        // full scan with the consumer stalled: units on rows 1, 3, 6
        lat_min = 1; lat_max = 1;
        for (int r = 0; r < 8; r++) begin
            row_static[r] = {6'd0, 6'd0, 6'd0, 6'(r + 1)};
            row_dyn[r] = 8'b00_00_00_10;
        end
        row_static[1] = {6'd0, 6'd0, 6'd0, 6'd17}; row_dyn[1] = 8'b00_00_00_00;
        row_static[3] = {6'd0, 6'd22, 6'd0, 6'd5}; row_dyn[3] = 8'b00_00_00_01;
        row_static[6] = {6'd40, 6'd0, 6'd0, 6'd0}; row_dyn[6] = 8'b11_00_00_00;
        ready_mode = 2;
        begin_pass(2);
        repeat (30) step();
        check_eq("stall_busy", m_busy, 1);
        check_eq("stall_at_row6", req_q.size(), 7);
        check_eq("stall_head_valid", m_res_valid, 1);
        check_eq("stall_head_row", m_res_row, 1);
        check_eq("stall_nothing_taken", got_q.size(), 0);
        ready_mode = 0;
        finish_pass(2, 0);

        // rows that must not emit: empty, and open slot alongside a true slot
        row_static[0] = 24'd0;                      row_dyn[0] = 8'h00;
        row_static[1] = {6'd0, 6'd0, 6'd21, 6'd20}; row_dyn[1] = 8'b00_00_00_10;
        row_static[2] = 24'd0;                      row_dyn[2] = 8'h55;
        row_static[3] = {6'd9, 6'd0, 6'd0, 6'd30};  row_dyn[3] = 8'b10_00_00_11;
        begin_pass(0);
        finish_pass(0, 0);
        check_eq("no_emit_rows", got_q.size(), 0);

        // randomized passes with latency 1..7, stray valids and random ready
        lat_min = 1; lat_max = 7; stray_en = 1;
        for (int k = 0; k < 24; k++) begin
            random_rows();
            ready_mode = int'($urandom_range(1, 0));
            begin_pass(k % 3);
            finish_pass(k % 3, (k % 4 == 0) ? 1 : 0);
        end

        // reset while waiting on row 3
        stray_en = 0; lat_min = 6; lat_max = 6; ready_mode = 1;
        random_rows();
        begin_pass(2);
        n = 0;
        while (req_q.size() < 4 && n < 200) begin step(); n++; end
        check_eq("reached_row3", req_q.size(), 4);
        step();
        rst = 1'b1;
        #1;
        check_outputs_zero("abort");
        repeat (3) step();
        check_eq("no_done_on_abort", done_cnt, 0);
        rst = 1'b0;
        step();
        inject_req++;
        step();
        step();
        check_eq("late_valid_ignored_busy", m_busy, 0);
        check_eq("late_valid_ignored_res", m_res_valid, 0);
        lat_min = 1; lat_max = 4;
        begin_pass(2);
        finish_pass(2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
